// File: rtl/btn_reset_ctrl.sv
// Button debouncer plus CPU reset sequencer and run/single-step controller.
// Optional feature macro: BTN_LONGPRESS_EN (a long hold of btn 1 leaves step mode).
module btn_reset_ctrl #(
  parameter int NUM_BTN          = 2,
  parameter int DEBOUNCE_CYCLES  = 65536,
  parameter int RESET_HOLD       = 16,
  parameter int LONGPRESS_CYCLES = 2**22
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               cpu_reset_n,
  output logic               step_mode,
  output logic               cpu_clk_en
);

  if (NUM_BTN < 2 || LONGPRESS_CYCLES < 1) begin : g_bad_param
    $error("btn_reset_ctrl: NUM_BTN must be >= 2 and LONGPRESS_CYCLES >= 1");
  end

  localparam int                DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int                HOLD_W  = $clog2(RESET_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  typedef enum logic [1:0] {HOLD, RUN, STEP, WAIT_REL} state_t;

  logic [NUM_BTN-1:0] sync1, sync2;
  logic [NUM_BTN-1:0] pressed;
  logic [DB_W-1:0]    db_cnt [NUM_BTN];

  state_t             state;
  logic               target_step;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               lp_hit;

  // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  assign pressed = ~sync2;

  // A level only flips after the synced input has disagreed with it for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      // NOTE: the counter array is small and must start from zero, so it is reset like any register.
      for (int i = 0; i < NUM_BTN; i++) db_cnt[i] <= '0;
    end else begin
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (pressed[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_level[i]   <= pressed[i];
          btn_press[i]   <= pressed[i];
          btn_release[i] <= ~pressed[i];
          db_cnt[i]      <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

`ifdef BTN_LONGPRESS_EN
  logic [31:0] lp_cnt;

  assign lp_hit = (state == STEP) && btn_level[1] && (lp_cnt == 32'(LONGPRESS_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset || state != STEP || !btn_level[1] || lp_hit) lp_cnt <= '0;
    else                                                    lp_cnt <= lp_cnt + 32'd1;
  end
`else
  assign lp_hit = 1'b0;
`endif

  // The reset edge doubles as HOLD entry, so both paths give RESET_HOLD low cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= HOLD;
      target_step <= 1'b0;
      hold_cnt    <= '0;
      cpu_reset_n <= 1'b0;
      step_mode   <= 1'b0;
      cpu_clk_en  <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state       <= target_step ? STEP : RUN;
            step_mode   <= target_step;
            cpu_reset_n <= 1'b1;
            cpu_clk_en  <= ~target_step;
            hold_cnt    <= '0;
          end else begin
            hold_cnt    <= hold_cnt + HOLD_W'(1);
            cpu_reset_n <= 1'b0;
            cpu_clk_en  <= 1'b1;
          end
        end
        RUN: begin
          if (btn_press[0]) begin
            state       <= HOLD;
            target_step <= 1'b0;
            hold_cnt    <= '0;
            cpu_reset_n <= 1'b0;
            cpu_clk_en  <= 1'b1;
          end else if (btn_press[1]) begin
            state       <= WAIT_REL;
            target_step <= 1'b1;
            cpu_clk_en  <= 1'b0;
          end else begin
            cpu_clk_en  <= 1'b1;
          end
        end
        STEP: begin
          if (btn_press[0]) begin
            state       <= HOLD;
            target_step <= 1'b1;
            hold_cnt    <= '0;
            cpu_reset_n <= 1'b0;
            cpu_clk_en  <= 1'b1;
          end else if (lp_hit) begin
            state       <= WAIT_REL;
            target_step <= 1'b0;
            cpu_clk_en  <= 1'b0;
          end else begin
            cpu_clk_en  <= btn_press[1];
          end
        end
        WAIT_REL: begin
          if (btn_level == '0) begin
            state      <= target_step ? STEP : RUN;
            step_mode  <= target_step;
            cpu_clk_en <= ~target_step;
          end else begin
            cpu_clk_en <= 1'b0;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule
